// File: rtl/clk_ce_gen.sv
// -----------------------------------------------------------------------------
// clk_ce_gen
//
// Clock-enable generator and PLL lock supervisor. It runs entirely in the PLL
// output clock domain. The raw PLL lock flag is brought into the domain and
// must be stable for LOCK_CYCLES consecutive cycles before the block releases
// the downstream system reset. Once locked, CHANNELS phase accumulators produce
// fractional-rate one-cycle clock-enable strobes:
//     f_ce = f_clk * inc / 2^ACC_W
//
// Parameters
//   CHANNELS     number of clock-enable channels (1..16)
//   ACC_W        phase accumulator / increment width (8..32)
//   LOCK_CYCLES  consecutive synchronised-lock cycles needed to lock (>= 2)
//
// Ports
//   clk        in   PLL output clock, the only clock of the block
//   reset_n    in   synchronous active-low reset
//   pll_lock   in   raw PLL lock, asynchronous to clk
//   wr_en      in   increment write strobe
//   wr_ch      in   channel index for the write (out-of-range writes ignored)
//   wr_inc     in   new increment value
//   lost_clr   in   clears the sticky lost_lock flag
//   ce         out  per-channel one-cycle enable strobes
//   locked     out  high while the supervisor is in the LOCKED state
//   sys_rst_n  out  active-low system reset for downstream logic (== locked)
//   lost_lock  out  sticky flag: lock was lost while LOCKED
// -----------------------------------------------------------------------------
module clk_ce_gen #(
    parameter  int CHANNELS    = 4,
    parameter  int ACC_W       = 24,
    parameter  int LOCK_CYCLES = 1024,
    localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int CNT_W       = $clog2(LOCK_CYCLES)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                pll_lock,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [ACC_W-1:0]    wr_inc,
    input  logic                lost_clr,
    output logic [CHANNELS-1:0] ce,
    output logic                locked,
    output logic                sys_rst_n,
    output logic                lost_lock
);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_COUNTING = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    // The transition into LOCKED happens on the edge that samples the
    // LOCK_CYCLES-th consecutive high lock_s. COUNTING is entered on the
    // first high sample with cnt=0, so that final sample sees cnt=LOCK_CYCLES-2
    // (the incremented count would be LOCK_CYCLES-1).
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 2);

    // Lock synchroniser and supervisor state
    logic                lock_s1_q;
    logic                lock_s_q;
    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                locked_q;
    logic                sys_rst_n_q;
    logic                lost_lock_q;

    // Per-channel rate generation
    logic [ACC_W-1:0]    inc_q [CHANNELS];
    logic [ACC_W-1:0]    acc_q [CHANNELS];
    logic [ACC_W:0]      sum_d [CHANNELS];
    logic [CHANNELS-1:0] ce_q;

    // Accumulate only while the supervisor stays in LOCKED across this edge.
    // Gating on the synchronised lock as well means the accumulators and
    // strobes clear on the same edge that locked falls, rather than one later.
    logic                run_acc;

    // Two-flop synchroniser: this is the only place pll_lock is sampled.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lock_s1_q <= 1'b0;
            lock_s_q  <= 1'b0;
        end else begin
            lock_s1_q <= pll_lock;
            lock_s_q  <= lock_s1_q;
        end
    end

    // Lock supervisor. locked and sys_rst_n are registered alongside the
    // state so both are high exactly while the state is LOCKED. lost_clr is
    // applied first so a loss of lock on the same edge still sets the flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_UNLOCKED;
            cnt_q       <= '0;
            locked_q    <= 1'b0;
            sys_rst_n_q <= 1'b0;
            lost_lock_q <= 1'b0;
        end else begin
            if (lost_clr) begin
                lost_lock_q <= 1'b0;
            end
            case (state_q)
                ST_UNLOCKED: begin
                    cnt_q <= '0;
                    if (lock_s_q) begin
                        state_q <= ST_COUNTING;
                    end
                end
                ST_COUNTING: begin
                    if (!lock_s_q) begin
                        state_q <= ST_UNLOCKED;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q     <= ST_LOCKED;
                        cnt_q       <= '0;
                        locked_q    <= 1'b1;
                        sys_rst_n_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_LOCKED: begin
                    if (!lock_s_q) begin
                        state_q     <= ST_UNLOCKED;
                        locked_q    <= 1'b0;
                        sys_rst_n_q <= 1'b0;
                        lost_lock_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_UNLOCKED;
                    cnt_q       <= '0;
                    locked_q    <= 1'b0;
                    sys_rst_n_q <= 1'b0;
                end
            endcase
        end
    end

    assign run_acc = (state_q == ST_LOCKED) && lock_s_q;

    // One extra bit on the sum captures the wrap of the accumulator; that
    // carry is exactly the enable strobe for the channel.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            sum_d[i] = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
        end
    end

    // Increment registers and accumulators. Writes are accepted in every
    // state and survive loss of lock; only reset clears them. A channel index
    // that matches no channel simply selects nothing. The accumulator is never
    // touched by a write, so the phase stays continuous across rate changes.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                inc_q[i] <= '0;
                acc_q[i] <= '0;
            end
            ce_q <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_en && (wr_ch == CH_W'(i))) begin
                    inc_q[i] <= wr_inc;
                end
                if (run_acc) begin
                    acc_q[i] <= sum_d[i][ACC_W-1:0];
                    ce_q[i]  <= sum_d[i][ACC_W];
                end else begin
                    acc_q[i] <= '0;
                    ce_q[i]  <= 1'b0;
                end
            end
        end
    end

    assign ce        = ce_q;
    assign locked    = locked_q;
    assign sys_rst_n = sys_rst_n_q;
    assign lost_lock = lost_lock_q;

endmodule
